data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 16 +
 rtl/data_mem_responder_mem_ram.sv | 22 ++
 rtl/data_mem_responder.sv | 104 ++++++++++
 tb/tb_data_mem_responder.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/data_mem_responder_pkg.sv
// data_mem_responder_pkg: shared widths, address map and FSM state type
package data_mem_responder_pkg;

    localparam int WORD_SIZE = 16;

    localparam logic [15:0] LEDR_ADDR = 16'h1000;
    localparam logic [15:0] SW_ADDR   = 16'h3000;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    // Error counter increment that sticks at its maximum instead of wrapping
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/data_mem_responder_mem_ram.sv
// mem_ram: single-port RAM with synchronous write and registered 1-cycle read
module mem_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is never reset; read data holds until the next read enable
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: processor data-bus responder for RAM, LED and switch registers
module data_mem_responder #(
    parameter int WORD_SIZE   = data_mem_responder_pkg::WORD_SIZE,
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataDone,
    input  logic [9:0]           SW,
    output logic [9:0]           LEDR,
    output logic [7:0]           ErrCount
);

    import data_mem_responder_pkg::*;

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    resp_state_t          state;
    logic [2:0]           wait_cnt;
    logic [9:0]           sw_meta;
    logic [9:0]           sw_sync;
    logic                 rd_q;
    logic                 ram_q;
    logic [WORD_SIZE-1:0] io_q;
    logic [WORD_SIZE-1:0] io_rdata;
    logic [WORD_SIZE-1:0] ram_rdata;
    logic [AW-1:0]        ram_addr;
    logic                 accept;
    logic                 ram_hit;
    logic                 led_hit;
    logic                 sw_hit;
    logic                 bad;
    logic                 ram_we;
    logic                 ram_re;

    assign ram_hit  = DataAddr < WORD_SIZE'(MEM_WORDS);
    assign led_hit  = DataAddr == WORD_SIZE'(LEDR_ADDR);
    assign sw_hit   = DataAddr == WORD_SIZE'(SW_ADDR);
    assign accept   = (ReadData | WriteData) && (state == IDLE || state == RESP);
    assign bad      = (ReadData & WriteData) | ~(ram_hit | led_hit | sw_hit) | (WriteData & sw_hit);
    assign ram_addr = ram_hit ? DataAddr[AW-1:0] : '0;
    assign ram_we   = accept && WriteData && ram_hit && !Reset;
    assign ram_re   = accept && !WriteData && ram_hit && !Reset;
    assign io_rdata = led_hit ? WORD_SIZE'(LEDR) : sw_hit ? WORD_SIZE'(sw_sync) : '0;
    assign DataDone = state == RESP;
    assign DataIn   = (state == RESP && rd_q) ? (ram_q ? ram_rdata : io_q) : '0;

    mem_ram #(
        .WIDTH(WORD_SIZE),
        .DEPTH(MEM_WORDS)
    ) u_ram (
        .clk  (Clock),
        .we   (ram_we),
        .re   (ram_re),
        .addr (ram_addr),
        .wdata(DataOut),
        .rdata(ram_rdata)
    );

    // Two-flop synchronizer bringing the switches into the clock domain
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= SW;
            sw_sync <= sw_meta;
        end
    end

    // Request FSM: accept in IDLE/RESP, optional wait countdown, one-cycle response
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            rd_q     <= 1'b0;
            ram_q    <= 1'b0;
            io_q     <= '0;
            LEDR     <= '0;
            ErrCount <= '0;
        end else if (accept) begin
            rd_q     <= ReadData & ~WriteData;
            ram_q    <= ram_hit;
            io_q     <= io_rdata;
            wait_cnt <= WAIT_INIT;
            state    <= (WAIT_STATES == 0) ? RESP : WAIT;
            if (WriteData && led_hit) LEDR <= DataOut[9:0];
            if (bad) ErrCount <= sat_inc(ErrCount);
        end else if (state == WAIT) begin
            if (wait_cnt == 3'd0) state <= RESP;
            else wait_cnt <= wait_cnt - 3'd1;
        end else if (state == RESP) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks for zero-wait and three-wait-state responders
module tb_data_mem_responder;

    logic        clk;
    logic        rst0, rst3;
    logic [15:0] addr0, wdat0, din0, addr3, wdat3, din3;
    logic        rd0, wr0, done0, rd3, wr3, done3;
    logic [9:0]  sw0, led0, sw3, led3;
    logic [7:0]  err0, err3;
    int          checks = 0;
    int          failures = 0;

    data_mem_responder #(.WORD_SIZE(16), .MEM_WORDS(256), .WAIT_STATES(0)) d0 (
        .Clock(clk), .Reset(rst0), .DataAddr(addr0), .DataOut(wdat0), .ReadData(rd0),
        .WriteData(wr0), .DataIn(din0), .DataDone(done0), .SW(sw0), .LEDR(led0), .ErrCount(err0)
    );

    data_mem_responder #(.WORD_SIZE(16), .MEM_WORDS(256), .WAIT_STATES(3)) d3 (
        .Clock(clk), .Reset(rst3), .DataAddr(addr3), .DataOut(wdat3), .ReadData(rd3),
        .WriteData(wr3), .DataIn(din3), .DataDone(done3), .SW(sw3), .LEDR(led3), .ErrCount(err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst0 = 1; rst3 = 1;
        addr0 = 0; wdat0 = 0; rd0 = 0; wr0 = 0; sw0 = 0;
        addr3 = 0; wdat3 = 0; rd3 = 0; wr3 = 0; sw3 = 0;
        step(); step();
        rst0 = 0; rst3 = 0;
        chk("rst_done", done0, 0);
        chk("rst_din", din0, 0);
        chk("rst_led", led0, 0);
        chk("rst_err", err0, 0);
        // RAM write then back-to-back read
        addr0 = 16'd5; wdat0 = 16'hBEEF; wr0 = 1;
        step();
        chk("wr5_done", done0, 1);
        chk("wr5_din", din0, 0);
        wr0 = 0; rd0 = 1;
        step();
        chk("rd5_done", done0, 1);
        chk("rd5_din", din0, 16'hBEEF);
        rd0 = 0;
        step();
        chk("idle_done", done0, 0);
        chk("idle_din", din0, 0);
        // LED register write and readback (upper data bits dropped)
        addr0 = 16'h1000; wdat0 = 16'hFFFF; wr0 = 1;
        step();
        chk("led_wr", led0, 10'h3FF);
        chk("led_wr_done", done0, 1);
        wr0 = 0; rd0 = 1;
        step();
        chk("led_rd", din0, 16'h03FF);
        rd0 = 0;
        step();
        // Switch read after synchronizer latency
        sw0 = 10'h155;
        step(); step(); step();
        addr0 = 16'h3000; rd0 = 1;
        step();
        chk("sw_rd", din0, 16'h0155);
        chk("sw_done", done0, 1);
        rd0 = 0;
        step();
        // Unmapped read
        addr0 = 16'h2000; rd0 = 1;
        step();
        chk("unm_din", din0, 0);
        chk("unm_done", done0, 1);
        chk("unm_err", err0, 1);
        rd0 = 0;
        step();
        // Read and write together: acts as write, returns zero, counts error
        addr0 = 16'd6; wdat0 = 16'h1234; rd0 = 1; wr0 = 1;
        step();
        chk("both_din", din0, 0);
        chk("both_err", err0, 2);
        wr0 = 0;
        step();
        chk("both_rd6", din0, 16'h1234);
        rd0 = 0;
        step();
        // Write to read-only switch address
        addr0 = 16'h3000; wdat0 = 16'hFFFF; wr0 = 1;
        step();
        chk("swwr_err", err0, 3);
        chk("swwr_done", done0, 1);
        wr0 = 0; rd0 = 1;
        step();
        chk("swwr_rd", din0, 16'h0155);
        rd0 = 0;
        step();
        // Saturation of the error counter
        addr0 = 16'h2000; rd0 = 1;
        repeat (300) step();
        rd0 = 0;
        step();
        chk("err_sat", err0, 8'd255);
        chk("ram5_keep", 32'(d0.u_ram.mem[5]), 16'hBEEF);
        // Wait-state write; changed data during WAIT must be ignored
        addr3 = 16'd7; wdat3 = 16'hA5A5; wr3 = 1;
        step();
        chk("w3_wr_e0", done3, 0);
        wdat3 = 16'h0000;
        step();
        chk("w3_wr_e1", done3, 0);
        step();
        chk("w3_wr_e2", done3, 0);
        step();
        chk("w3_wr_done", done3, 1);
        wr3 = 0;
        step();
        chk("w3_wr_idle", done3, 0);
        // Wait-state read: data four cycles after the request cycle
        rd3 = 1;
        step();
        chk("w3_rd_e0", done3, 0);
        chk("w3_rd_din0", din3, 0);
        step(); step();
        chk("w3_rd_e2", done3, 0);
        step();
        chk("w3_rd_done", done3, 1);
        chk("w3_rd_din", din3, 16'hA5A5);
        rd3 = 0;
        step();
        // LED write through the wait-state responder
        addr3 = 16'h1000; wdat3 = 16'h02AA; wr3 = 1;
        step();
        chk("w3_led", led3, 10'h2AA);
        step(); step(); step();
        chk("w3_led_done", done3, 1);
        wr3 = 0;
        step();
        // Reset in the middle of a waiting read
        addr3 = 16'd7; rd3 = 1;
        step(); step();
        #2;
        rst3 = 1; rd3 = 0;
        #1;
        chk("mid_rst_done", done3, 0);
        chk("mid_rst_led", led3, 0);
        chk("mid_rst_din", din3, 0);
        step();
        chk("mid_rst_done2", done3, 0);
        step();
        rst3 = 0; rd3 = 1;
        step();
        chk("post_rst_e0", done3, 0);
        step(); step();
        chk("post_rst_e2", done3, 0);
        step();
        chk("post_rst_done", done3, 1);
        chk("post_rst_ram", din3, 16'hA5A5);
        rd3 = 0;
        step();
        chk("post_rst_idle", done3, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
